// File: rtl/vdmem_pkg.sv
// Shared types and default sizes for the vector data memory.
package vdmem_pkg;

  localparam int VDMEM_N     = 8;
  localparam int VDMEM_R     = 6;
  localparam int VDMEM_DEPTH = 1024;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DUMP_RD,
    ST_DUMP_OUT
  } vdmem_state_e;

endpackage

// File: rtl/vdmem_stream_ctrl.sv
// Host stream controller: mode FSM, lane/vector counters and the byte
// handshakes for preload (LOAD) and dump (DUMP_RD/DUMP_OUT).
module vdmem_stream_ctrl
  import vdmem_pkg::*;
#(
  parameter int R     = VDMEM_R,
  parameter int DEPTH = VDMEM_DEPTH,
  localparam int LW   = (R > 1) ? $clog2(R) : 1,
  localparam int VW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_start,
  input  logic          dump_start,
  input  logic          in_valid,
  input  logic          out_ready,
  output logic          in_ready,
  output logic          out_valid,
  output logic          busy,
  output logic          done,
  output logic          host_we,
  output logic          hold_load,
  output logic [VW-1:0] host_addr,
  output logic [LW-1:0] host_lane
);

  localparam logic [LW-1:0] LANE_LAST = LW'(R - 1);
  localparam logic [VW-1:0] VEC_LAST  = VW'(DEPTH - 1);

  vdmem_state_e  state_q, state_d;
  logic [LW-1:0] lane_q, lane_d;
  logic [VW-1:0] vec_q, vec_d;
  logic          done_q, done_d;

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign host_addr = vec_q;
  assign host_lane = lane_q;

  // State and counter registers; reset aborts any stream with no done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      lane_q  <= '0;
      vec_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      vec_q   <= vec_d;
      done_q  <= done_d;
    end
  end

  // Next state, counter advance and handshake outputs.
  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    vec_d     = vec_q;
    done_d    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    host_we   = 1'b0;
    hold_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        lane_d = '0;
        vec_d  = '0;
        // Load takes priority when both starts arrive together.
        if (load_start)      state_d = ST_LOAD;
        else if (dump_start) state_d = ST_DUMP_RD;
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          host_we = 1'b1;
          if (lane_q == LANE_LAST) begin
            lane_d = '0;
            if (vec_q == VEC_LAST) begin
              vec_d   = '0;
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              vec_d = vec_q + 1'b1;
            end
          end else begin
            lane_d = lane_q + 1'b1;
          end
        end
      end
      ST_DUMP_RD: begin
        hold_load = 1'b1;
        state_d   = ST_DUMP_OUT;
      end
      ST_DUMP_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (lane_q == LANE_LAST) begin
            lane_d = '0;
            if (vec_q == VEC_LAST) begin
              vec_d   = '0;
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              vec_d   = vec_q + 1'b1;
              state_d = ST_DUMP_RD;
            end
          end else begin
            lane_d = lane_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/vector_data_memory.sv
// Lane-parallel vector data memory with a CPU port and a byte-stream host
// port for preload/dump. Optional bounds checking on the CPU address is
// enabled by defining VDMEM_BOUNDS_CHECK_EN; otherwise the CPU address is
// taken modulo 2**clog2(DEPTH) and addr_err is tied low.
module vector_data_memory
  import vdmem_pkg::*;
#(
  parameter int I     = 32,
  parameter int N     = VDMEM_N,
  parameter int R     = VDMEM_R,
  parameter int DEPTH = VDMEM_DEPTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                MemWrite,
  input  logic [I-1:0]        Address,
  input  logic [R-1:0][N-1:0] WriteData,
  output logic [R-1:0][N-1:0] ReadData,
  input  logic                load_start,
  input  logic                dump_start,
  input  logic                in_valid,
  input  logic [N-1:0]        in_data,
  output logic                in_ready,
  output logic                out_valid,
  output logic [N-1:0]        out_data,
  input  logic                out_ready,
  output logic                Busy,
  output logic                done,
  output logic                addr_err
);

  localparam int LW = (R > 1) ? $clog2(R) : 1;
  localparam int VW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                host_we, hold_load;
  logic [VW-1:0]       host_addr, cpu_idx, mem_addr;
  logic [LW-1:0]       host_lane;
  logic                in_range;
  logic [R-1:0][N-1:0] rd_raw;
  logic [R-1:0][N-1:0] hold;

  vdmem_stream_ctrl #(.R(R), .DEPTH(DEPTH)) u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .load_start(load_start),
    .dump_start(dump_start),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .busy      (Busy),
    .done      (done),
    .host_we   (host_we),
    .hold_load (hold_load),
    .host_addr (host_addr),
    .host_lane (host_lane)
  );

  assign cpu_idx = Address[VW-1:0];

`ifdef VDMEM_BOUNDS_CHECK_EN
  assign in_range = (Address < I'(DEPTH));

  // Sticky flag: any CPU access beyond DEPTH while the CPU port is live.
  always_ff @(posedge clk) begin
    if (reset)                   addr_err <= 1'b0;
    else if (!Busy && !in_range) addr_err <= 1'b1;
  end
`else
  // Upper address bits are deliberately ignored (address wraps).
  logic unused_addr_hi;
  assign unused_addr_hi = ^Address[I-1:VW];
  assign in_range       = 1'b1;
  assign addr_err       = 1'b0;
`endif

  // The host owns the RAM address whenever a stream is in progress.
  assign mem_addr = Busy ? host_addr : cpu_idx;

  for (genvar l = 0; l < R; l++) begin : g_lane
    logic [N-1:0] mem [DEPTH];
    logic         we;
    logic [N-1:0] wd;

    // CPU writes are dropped while busy; reset blocks a write in flight.
    assign we = !reset && (Busy ? (host_we && host_lane == LW'(l))
                                : (MemWrite && in_range));
    assign wd = Busy ? in_data : WriteData[l];

    // Lane RAM write; contents survive reset.
    always_ff @(posedge clk) begin
      if (we) mem[mem_addr] <= wd;
    end

    assign rd_raw[l] = mem[mem_addr];
  end

  // CPU read register: old contents on same-address write, held while busy.
  always_ff @(posedge clk) begin
    if (reset)      ReadData <= '0;
    else if (!Busy) ReadData <= in_range ? rd_raw : '0;
  end

  // Dump holding register, filled once per vector in DUMP_RD.
  always_ff @(posedge clk) begin
    if (reset)          hold <= '0;
    else if (hold_load) hold <= rd_raw;
  end

  assign out_data = hold[host_lane];

endmodule

// File: tb/tb_vector_data_memory.sv
// Directed bench for vector_data_memory (DEPTH=8, R=6, N=8) with
// scoreboard queues for CPU reads and dump bytes.
module tb_vector_data_memory;

  localparam int I = 32, N = 8, R = 6, DEPTH = 8;
  localparam int NB = DEPTH * R;

  logic                clk = 1'b0;
  logic                reset;
  logic                MemWrite;
  logic [I-1:0]        Address;
  logic [R-1:0][N-1:0] WriteData;
  logic [R-1:0][N-1:0] ReadData;
  logic                load_start, dump_start;
  logic                in_valid, in_ready;
  logic [N-1:0]        in_data;
  logic                out_valid, out_ready;
  logic [N-1:0]        out_data;
  logic                Busy, done, addr_err;

  vector_data_memory #(.I(I), .N(N), .R(R), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .Address(Address),
    .WriteData(WriteData), .ReadData(ReadData), .load_start(load_start),
    .dump_start(dump_start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .Busy(Busy), .done(done), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_fail = 0, n_tot = 0;
  int done_cnt = 0;
  logic [R*N-1:0] rd_q[$];
  logic [N-1:0]   byte_q[$];

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [R*N-1:0] ramp(input int base);
    logic [R*N-1:0] v;
    for (int l = 0; l < R; l++) v[l*N +: N] = N'(base + l);
    return v;
  endfunction

  // Present a CPU access; the expected read is queued now, checked after the edge.
  task automatic cpu_acc(input string tag, input int addr, input logic we,
                         input logic [R*N-1:0] wd, input logic [R*N-1:0] exp);
    Address   = I'(addr);
    MemWrite  = we;
    WriteData = wd;
    rd_q.push_back(exp);
    step();
    chk(tag, ReadData, rd_q.pop_front());
    MemWrite = 1'b0;
  endtask

  initial begin
    logic [R*N-1:0] vec1_mix;
    logic [N-1:0]   stall_val;
    logic           stalled;
    int             p, stall_err;
    logic           consumed;

    reset = 1'b1; MemWrite = 1'b0; Address = '0; WriteData = '0;
    load_start = 1'b0; dump_start = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0;
    step(); step();
    chk("rst_readdata", ReadData, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr_err", addr_err, 0);
    reset = 1'b0;

    // CPU: seed vec 5, overwrite while reading (old value back), then read new.
    Address = 5; MemWrite = 1'b1; WriteData = {R{8'h33}};
    step();
    cpu_acc("cpu_rbw", 5, 1'b1, ramp(1), {R{8'h33}});
    cpu_acc("cpu_rd5", 5, 1'b0, '0, ramp(1));

    // LOAD 48 bytes with every third cycle idle.
    done_cnt = 0;
    load_start = 1'b1; step(); load_start = 1'b0;
    chk("load_busy", Busy, 1);
    chk("load_in_ready", in_ready, 1);
    p = 0;
    for (int c = 0; c < 400 && p < NB; c++) begin
      in_valid = (c % 3 != 2);
      in_data  = N'(p);
      consumed = in_valid && in_ready;
      step();
      if (consumed) p++;
    end
    in_valid = 1'b0;
    chk("load_bytes", p, NB);
    chk("load_done", done, 1);
    chk("load_busy_low", Busy, 0);
    step();
    chk("load_done_once", done_cnt, 1);
    cpu_acc("load_vec2", 2, 1'b0, '0, ramp(12));
    cpu_acc("load_vec5", 5, 1'b0, '0, ramp(30));

    // DUMP with out_ready toggling; bytes must appear 0..47 in order.
    done_cnt = 0;
    for (int b = 0; b < NB; b++) byte_q.push_back(N'(b));
    dump_start = 1'b1; step(); dump_start = 1'b0;
    chk("dump_busy", Busy, 1);
    stalled = 1'b0; stall_err = 0; stall_val = '0;
    for (int c = 0; c < 600 && byte_q.size() > 0; c++) begin
      out_ready = c[0];
      if (stalled && out_valid && out_data !== stall_val) stall_err++;
      stalled = out_valid && !out_ready;
      stall_val = out_data;
      if (out_valid && out_ready) chk("dump_byte", out_data, byte_q.pop_front());
      step();
    end
    out_ready = 1'b0;
    chk("dump_remaining", byte_q.size(), 0);
    chk("dump_stall_hold", stall_err, 0);
    chk("dump_done", done, 1);
    chk("dump_busy_low", Busy, 0);
    step();
    chk("dump_done_once", done_cnt, 1);
    chk("dump_out_valid_low", out_valid, 0);

    // Both starts together: LOAD wins; CPU write during LOAD is dropped;
    // reset after 10 bytes aborts with no done.
    done_cnt = 0;
    load_start = 1'b1; dump_start = 1'b1; step();
    load_start = 1'b0; dump_start = 1'b0;
    chk("both_in_ready", in_ready, 1);
    chk("both_out_valid", out_valid, 0);
    Address = 7; MemWrite = 1'b1; WriteData = {R{8'hEE}};
    step();
    MemWrite = 1'b0;
    for (int b = 0; b < 10; b++) begin
      in_valid = 1'b1;
      in_data  = N'(8'h80 + b);
      step();
    end
    in_valid = 1'b0;
    reset = 1'b1; step(); reset = 1'b0;
    chk("abort_busy", Busy, 0);
    chk("abort_in_ready", in_ready, 0);
    step();
    chk("abort_no_done", done_cnt, 0);
    vec1_mix = {8'h0B, 8'h0A, 8'h89, 8'h88, 8'h87, 8'h86};
    cpu_acc("abort_vec0", 0, 1'b0, '0, ramp(8'h80));
    cpu_acc("abort_vec1", 1, 1'b0, '0, vec1_mix);
    cpu_acc("dropped_wr_vec7", 7, 1'b0, '0, ramp(42));

    // Out-of-range address DEPTH+1.
`ifdef VDMEM_BOUNDS_CHECK_EN
    cpu_acc("oob_wr_read", DEPTH + 1, 1'b1, {R{8'hAA}}, '0);
    chk("oob_addr_err", addr_err, 1);
    cpu_acc("oob_vec1", 1, 1'b0, '0, vec1_mix);
    chk("oob_addr_err_sticky", addr_err, 1);
`else
    cpu_acc("wrap_wr_read", DEPTH + 1, 1'b1, {R{8'hAA}}, vec1_mix);
    cpu_acc("wrap_vec1", 1, 1'b0, '0, {R{8'hAA}});
    chk("wrap_addr_err", addr_err, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
